// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to instruction memory and
// feeds {PC, instr, valid} to IF/ID through registered outputs plus a 1-entry skid buffer.
// Optional misaligned-redirect trap: define IF_MISALIGN_CHK_EN.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] instr_out,
    output logic        valid_out,
    output logic        fetch_misalign
);

`ifdef IF_MISALIGN_CHK_EN
    typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_HOLD, ST_ERR} state_t;
`else
    typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_HOLD} state_t;
`endif

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        kill_reg, kill_next;
    logic        misalign_reg, misalign_next;
    logic [31:0] skid_pc_reg, skid_instr_reg;
    logic [31:0] pc_out_reg, instr_out_reg;
    logic        valid_out_reg;

    logic [31:0] redir_target;
    logic        redir_bad;
    logic        in_err;
    logic        load_mem, load_skid, to_skid;

`ifdef IF_MISALIGN_CHK_EN
    assign redir_target = redirect_pc;
    assign redir_bad    = redirect && (redirect_pc[1:0] != 2'b00);
    assign in_err       = (state_reg == ST_ERR);
`else
    // Without the trap, targets are silently word-aligned.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redir_target = {redirect_pc[31:2], 2'b00};
    assign redir_bad    = 1'b0;
    assign in_err       = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        kill_next     = kill_reg;
        misalign_next = misalign_reg;
        imem_req      = 1'b0;
        imem_addr     = pc_reg;
        load_mem      = 1'b0;
        load_skid     = 1'b0;
        to_skid       = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                // A redirect in FETCH is forwarded straight to memory: no extra penalty.
                if (!rst && !redir_bad) begin
                    imem_req   = 1'b1;
                    imem_addr  = redirect ? redir_target : pc_reg;
                    pc_next    = redirect ? redir_target : pc_reg;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_reg || redirect) begin
                        kill_next  = 1'b0;
                        state_next = ST_FETCH;
                        if (redirect)
                            pc_next = redir_target;
                    end else if (!valid_out_reg || !stall) begin
                        load_mem   = 1'b1;
                        pc_next    = pc_reg + 32'd4;
                        state_next = ST_FETCH;
                    end else begin
                        to_skid    = 1'b1;
                        pc_next    = pc_reg + 32'd4;
                        state_next = ST_HOLD;
                    end
                end else if (redirect) begin
                    // Response still in flight: remember to drop it when it lands.
                    pc_next   = redir_target;
                    kill_next = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_next    = redir_target;
                    state_next = ST_FETCH;
                end else if (!stall) begin
                    load_skid  = 1'b1;
                    state_next = ST_FETCH;
                end
            end
`ifdef IF_MISALIGN_CHK_EN
            ST_ERR: begin
                if (redirect && !redir_bad) begin
                    pc_next       = redir_target;
                    misalign_next = 1'b0;
                    state_next    = ST_FETCH;
                end
            end
`endif
            default: state_next = ST_FETCH;
        endcase
`ifdef IF_MISALIGN_CHK_EN
        if (redir_bad) begin
            state_next    = ST_ERR;
            misalign_next = 1'b1;
            kill_next     = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_FETCH;
            pc_reg         <= RESET_PC;
            kill_reg       <= 1'b0;
            misalign_reg   <= 1'b0;
            skid_pc_reg    <= 32'd0;
            skid_instr_reg <= NOP_INSTR;
            pc_out_reg     <= 32'd0;
            instr_out_reg  <= NOP_INSTR;
            valid_out_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            kill_reg     <= kill_next;
            misalign_reg <= misalign_next;
            if (to_skid) begin
                skid_pc_reg    <= pc_reg;
                skid_instr_reg <= imem_rdata;
            end
            // Redirect beats stall; the trap keeps the faulting target visible on PC_out.
            if (redir_bad) begin
                pc_out_reg    <= redirect_pc;
                instr_out_reg <= NOP_INSTR;
                valid_out_reg <= 1'b0;
            end else if (redirect) begin
                pc_out_reg    <= 32'd0;
                instr_out_reg <= NOP_INSTR;
                valid_out_reg <= 1'b0;
            end else if (load_mem) begin
                pc_out_reg    <= pc_reg;
                instr_out_reg <= imem_rdata;
                valid_out_reg <= 1'b1;
            end else if (load_skid) begin
                pc_out_reg    <= skid_pc_reg;
                instr_out_reg <= skid_instr_reg;
                valid_out_reg <= 1'b1;
            end else if (!stall && !in_err) begin
                pc_out_reg    <= 32'd0;
                instr_out_reg <= NOP_INSTR;
                valid_out_reg <= 1'b0;
            end
        end
    end

    assign PC_out         = pc_out_reg;
    assign instr_out      = instr_out_reg;
    assign valid_out      = valid_out_reg;
    assign fetch_misalign = misalign_reg;

endmodule
